// File: rtl/fir_mc_datapath_pkg.sv
// -----------------------------------------------------------------------------
// fir_mc_datapath_pkg
// Shared types for the multi-channel FIR datapath:
//   fir_mc_state_t : datapath mode (LOAD_H, RUN, DRAIN)
//   fir_mc_ctrl_t  : right_shift amount and the reload_h pulse
//   fir_mc_flags_t : state, current channel pointer, coeff_valid
//   acc_w()        : accumulator width that cannot overflow for a given
//                    sample width and tap count
// Optional feature macro (used by fir_mc_dot): FIR_MC_ROUND_EN
// -----------------------------------------------------------------------------
package fir_mc_datapath_pkg;

  // Channel pointer field in the flags struct is fixed-width so the struct
  // does not depend on NB_CHANNELS; the pointer is zero-extended into it.
  localparam int unsigned CHAN_PTR_W = 8;
  localparam int unsigned SHIFT_W    = 6;

  typedef enum logic [1:0] {
    LOAD_H = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } fir_mc_state_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] right_shift;
    logic               reload_h;
  } fir_mc_ctrl_t;

  typedef struct packed {
    fir_mc_state_t         state;
    logic [CHAN_PTR_W-1:0] chan;
    logic                  coeff_valid;
  } fir_mc_flags_t;

  function automatic int unsigned acc_w(input int unsigned data_width,
                                        input int unsigned nb_taps);
    return 2 * data_width + $clog2(nb_taps);
  endfunction

endpackage

// File: rtl/fir_mc_datapath_dot.sv
// -----------------------------------------------------------------------------
// fir_mc_dot
// Purely combinational signed dot product of NB_TAPS samples and coefficients,
// followed by an arithmetic right shift and saturation to DATA_WIDTH.
// Ports:
//   samples_i     : NB_TAPS samples, index 0 = newest
//   coeffs_i      : NB_TAPS coefficients, index 0 multiplies the newest sample
//   right_shift_i : shift amount; values >= ACC_W act as ACC_W-1
//   result_o      : shifted, saturated result
// Macro FIR_MC_ROUND_EN: round half up before the shift; otherwise truncate.
// -----------------------------------------------------------------------------
module fir_mc_dot
  import fir_mc_datapath_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NB_TAPS    = 50
) (
  input  logic [DATA_WIDTH-1:0] samples_i [NB_TAPS],
  input  logic [DATA_WIDTH-1:0] coeffs_i  [NB_TAPS],
  input  logic [SHIFT_W-1:0]    right_shift_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = acc_w(DATA_WIDTH, NB_TAPS);
  // One extra bit so the rounding increment can never wrap the accumulator.
  localparam int unsigned SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PROD_W-1:0] s_ext, c_ext, prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SUM_W-1:0]  acc_rnd, shifted;
  logic [SHIFT_W-1:0]       shamt;

  always_comb begin
    // NOTE: every variable gets a value before any conditional use, so no
    // path through this block can leave one unassigned and infer a latch.
    acc   = '0;
    s_ext = '0;
    c_ext = '0;
    prod  = '0;
    for (int k = 0; k < NB_TAPS; k++) begin
      s_ext = PROD_W'($signed(samples_i[k]));
      c_ext = PROD_W'($signed(coeffs_i[k]));
      prod  = s_ext * c_ext;
      acc   = acc + ACC_W'(prod);
    end

    if (int'(right_shift_i) >= ACC_W) shamt = SHIFT_W'(ACC_W - 1);
    else                              shamt = right_shift_i;

    acc_rnd = SUM_W'(acc);
`ifdef FIR_MC_ROUND_EN
    if (shamt != '0) acc_rnd = acc_rnd + (SUM_W'(1) << (shamt - 1'b1));
`endif
    shifted = acc_rnd >>> shamt;

    if (shifted > SAT_MAX)      result_o = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) result_o = SAT_MIN[DATA_WIDTH-1:0];
    else                        result_o = shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/fir_mc_datapath.sv
// -----------------------------------------------------------------------------
// fir_mc_datapath
// Time-interleaved multi-channel FIR: NB_CHANNELS delay lines share one
// coefficient set that is loaded serially over the h stream.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   clear_i           : synchronous soft clear (delay lines, channel, y.valid)
//   ctrl_i            : right_shift, reload_h pulse
//   flags_o           : state, channel pointer, coeff_valid
//   x_*               : input samples, round-robin channel order
//   h_*               : coefficients, beat k -> tap k
//   y_*               : filtered output, same channel order as x
//   y_chan_o          : channel of the current y beat
// Macro FIR_MC_ROUND_EN: see fir_mc_dot (rounding before the output shift).
// -----------------------------------------------------------------------------
module fir_mc_datapath
  import fir_mc_datapath_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 16,
  parameter  int unsigned NB_TAPS     = 50,
  parameter  int unsigned NB_CHANNELS = 4,
  localparam int unsigned CHAN_W      = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1,
  localparam int unsigned STRB_W      = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  fir_mc_ctrl_t          ctrl_i,
  output fir_mc_flags_t         flags_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [DATA_WIDTH-1:0] h_data_i,
  input  logic                  h_valid_i,
  output logic                  h_ready_o,
  output logic [DATA_WIDTH-1:0] y_data_o,
  output logic [STRB_W-1:0]     y_strb_o,
  output logic                  y_valid_o,
  input  logic                  y_ready_i,
  output logic [CHAN_W-1:0]     y_chan_o
);

  localparam int unsigned IDX_W = $clog2(NB_TAPS);

  fir_mc_state_t         state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CHAN_W-1:0]     chan_q, chan_d;
  logic                  coeff_valid_q;
  logic [DATA_WIDTH-1:0] coef_q [NB_TAPS];
  logic [DATA_WIDTH-1:0] line_q [NB_CHANNELS][NB_TAPS];
  logic [DATA_WIDTH-1:0] line_d [NB_TAPS];
  logic [DATA_WIDTH-1:0] dot_res;
  logic                  y_valid_q;
  logic [DATA_WIDTH-1:0] y_data_q;
  logic [CHAN_W-1:0]     y_chan_q;
  logic                  x_hs, h_hs, y_hs;

  // Ready is combinational from state so the upstream sources see it in the
  // same cycle; clear blocks x so no sample is consumed and then discarded.
  assign h_ready_o = (state_q == LOAD_H);
  assign x_ready_o = (state_q == RUN) & ~clear_i & (~y_valid_q | y_ready_i);

  assign x_hs = x_valid_i & x_ready_o;
  assign h_hs = h_valid_i & h_ready_o;
  assign y_hs = y_valid_q & y_ready_i;

  assign chan_d = (chan_q == CHAN_W'(NB_CHANNELS - 1)) ? '0 : chan_q + 1'b1;

  // Delay line of the current channel as it looks after accepting x_data_i;
  // the output is computed on this so the new sample contributes immediately.
  always_comb begin
    line_d[0] = x_data_i;
    for (int k = 1; k < NB_TAPS; k++) line_d[k] = line_q[chan_q][k-1];
  end

  fir_mc_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB_TAPS    (NB_TAPS)
  ) u_dot (
    .samples_i     (line_d),
    .coeffs_i      (coef_q),
    .right_shift_i (ctrl_i.right_shift),
    .result_o      (dot_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= LOAD_H;
      idx_q         <= '0;
      chan_q        <= '0;
      coeff_valid_q <= 1'b0;
      y_valid_q     <= 1'b0;
      y_data_q      <= '0;
      y_chan_q      <= '0;
      // NOTE: the coefficient and delay-line arrays are reset explicitly:
      // the filter must restart from a known all-zero history, so they are
      // plain registers rather than a RAM that could be left uninitialised.
      for (int k = 0; k < NB_TAPS; k++) coef_q[k] <= '0;
      for (int c = 0; c < NB_CHANNELS; c++)
        for (int k = 0; k < NB_TAPS; k++) line_q[c][k] <= '0;
    end else begin
      // NOTE: non-blocking updates let later assignments in this block win,
      // so a new result below overrides this drop of y_valid in one cycle.
      if (y_hs) y_valid_q <= 1'b0;

      case (state_q)
        LOAD_H: begin
          if (h_hs) begin
            coef_q[idx_q] <= h_data_i;
            if (idx_q == IDX_W'(NB_TAPS - 1)) begin
              idx_q         <= '0;
              coeff_valid_q <= 1'b1;
              state_q       <= RUN;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (x_hs) begin
            for (int k = 0; k < NB_TAPS; k++) line_q[chan_q][k] <= line_d[k];
            y_data_q  <= dot_res;
            y_chan_q  <= chan_q;
            y_valid_q <= 1'b1;
            chan_q    <= chan_d;
          end
          if (ctrl_i.reload_h) state_q <= DRAIN;
        end
        DRAIN: begin
          // Wait for the last result to leave before accepting new taps.
          if (!y_valid_q || y_ready_i) begin
            state_q       <= LOAD_H;
            coeff_valid_q <= 1'b0;
            idx_q         <= '0;
          end
        end
        default: state_q <= LOAD_H;
      endcase

      if (clear_i) begin
        for (int c = 0; c < NB_CHANNELS; c++)
          for (int k = 0; k < NB_TAPS; k++) line_q[c][k] <= '0;
        chan_q    <= '0;
        y_valid_q <= 1'b0;
        if (state_q == DRAIN) begin
          state_q       <= LOAD_H;
          coeff_valid_q <= 1'b0;
          idx_q         <= '0;
        end
      end
    end
  end

  assign y_data_o  = y_data_q;
  assign y_strb_o  = '1;
  assign y_valid_o = y_valid_q;
  assign y_chan_o  = y_chan_q;

  assign flags_o.state       = state_q;
  assign flags_o.chan        = CHAN_PTR_W'(chan_q);
  assign flags_o.coeff_valid = coeff_valid_q;

endmodule

// File: tb/tb_fir_mc_datapath.sv
// -----------------------------------------------------------------------------
// tb_fir_mc_datapath
// Self-checking bench for fir_mc_datapath (DATA_WIDTH=16, NB_TAPS=4,
// NB_CHANNELS=2). A reference model tracks per-channel sample history and the
// loaded coefficients and predicts every y beat with plain integer arithmetic.
// Honours FIR_MC_ROUND_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fir_mc_datapath;
  import fir_mc_datapath_pkg::*;

  localparam int DW   = 16;
  localparam int NT   = 4;
  localparam int NC   = 2;
  localparam int CW   = 1;
  localparam int ACCW = 2 * DW + 2;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic            clear_i = 1'b0;
  fir_mc_ctrl_t    ctrl_i;
  fir_mc_flags_t   flags_o;
  logic [DW-1:0]   x_data_i, h_data_i, y_data_o;
  logic            x_valid_i, x_ready_o, h_valid_i, h_ready_o;
  logic            y_valid_o, y_ready_i;
  logic [1:0]      y_strb_o;
  logic [CW-1:0]   y_chan_o;

  fir_mc_datapath #(
    .DATA_WIDTH  (DW),
    .NB_TAPS     (NT),
    .NB_CHANNELS (NC)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .ctrl_i    (ctrl_i),
    .flags_o   (flags_o),
    .x_data_i  (x_data_i),
    .x_valid_i (x_valid_i),
    .x_ready_o (x_ready_o),
    .h_data_i  (h_data_i),
    .h_valid_i (h_valid_i),
    .h_ready_o (h_ready_o),
    .y_data_o  (y_data_o),
    .y_strb_o  (y_strb_o),
    .y_valid_o (y_valid_o),
    .y_ready_i (y_ready_i),
    .y_chan_o  (y_chan_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] w(input int v);
    return v[DW-1:0];
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chan;
  } ybeat_t;

  logic signed [DW-1:0] mcoef [NT];
  logic signed [DW-1:0] hist  [NC][NT];
  int                   mch, hidx;
  ybeat_t               exp_q[$];
  ybeat_t               ylog[$];

  function automatic logic [DW-1:0] model_out(input int c, input int sh);
    longint acc = 0;
    int     s;
    for (int k = 0; k < NT; k++) acc += longint'(hist[c][k]) * longint'(mcoef[k]);
    s = (sh >= ACCW) ? ACCW - 1 : sh;
`ifdef FIR_MC_ROUND_EN
    if (s > 0) acc += longint'(1) <<< (s - 1);
`endif
    acc = acc >>> s;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      for (int c = 0; c < NC; c++) for (int k = 0; k < NT; k++) hist[c][k] = '0;
      for (int k = 0; k < NT; k++) mcoef[k] = '0;
      mch  = 0;
      hidx = 0;
    end else begin
      if (y_valid_o && y_ready_i) begin
        if (exp_q.size() == 0) begin
          check("y_unexpected", 32'(exp_q.size()), 1);
        end else begin
          ybeat_t e;
          e = exp_q.pop_front();
          check("y_data", y_data_o, e.data);
          check("y_chan", y_chan_o, e.chan);
          ylog.push_back('{y_data_o, y_chan_o});
        end
      end
      if (clear_i) begin
        exp_q.delete();
        for (int c = 0; c < NC; c++) for (int k = 0; k < NT; k++) hist[c][k] = '0;
        mch = 0;
      end else if (x_valid_i && x_ready_o) begin
        for (int k = NT - 1; k > 0; k--) hist[mch][k] = hist[mch][k-1];
        hist[mch][0] = x_data_i;
        exp_q.push_back('{model_out(mch, int'(ctrl_i.right_shift)), CW'(mch)});
        mch = (mch + 1) % NC;
      end
      if (h_valid_i && h_ready_o) begin
        mcoef[hidx] = h_data_i;
        hidx = (hidx + 1) % NT;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_x(input logic [DW-1:0] d);
    bit got = 1'b0;
    x_valid_i = 1'b1;
    x_data_i  = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = x_ready_o;
      tick();
    end
    x_valid_i = 1'b0;
    check("x_hs", 32'(got), 1);
  endtask

  task automatic load_h(input logic [NT-1:0][DW-1:0] hv);
    for (int k = 0; k < NT; k++) begin
      bit got = 1'b0;
      h_valid_i = 1'b1;
      h_data_i  = hv[k];
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        got = h_ready_o;
        tick();
      end
      check("h_hs", 32'(got), 1);
    end
    h_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    tick();
    check("y_drain", 32'(exp_q.size()), 0);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic reload(input logic [NT-1:0][DW-1:0] hv);
    bit got = 1'b0;
    ctrl_i.reload_h = 1'b1;
    tick();
    ctrl_i.reload_h = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      got = h_ready_o;
      if (!got) tick();
    end
    check("reload_h_ready", 32'(got), 1);
    load_h(hv);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_y_valid"}, 32'(y_valid_o), 0);
    check({tag, "_y_data"}, y_data_o, 0);
    check({tag, "_y_strb"}, y_strb_o, 2'b11);
    check({tag, "_y_chan"}, y_chan_o, 0);
    check({tag, "_x_ready"}, 32'(x_ready_o), 0);
    check({tag, "_h_ready"}, 32'(h_ready_o), 1);
    check({tag, "_state"}, flags_o.state, LOAD_H);
    check({tag, "_coeff_valid"}, 32'(flags_o.coeff_valid), 0);
    check({tag, "_chan_ptr"}, flags_o.chan, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int imp [5] = '{1, 2, 3, 4, 0};
    int iso [5] = '{100, 200, 300, 400, 400};
    int xs  [6];
    int base;

    ctrl_i    = '0;
    x_valid_i = 1'b0;
    x_data_i  = '0;
    h_valid_i = 1'b0;
    h_data_i  = '0;
    y_ready_i = 1'b1;

    #2 rst_ni = 1'b0;
    #3 check_reset_values("rst");
    tick();
    rst_ni = 1'b1;
    tick();

    // Impulse response
    load_h({16'd4, 16'd3, 16'd2, 16'd1});
    check("load_state", flags_o.state, RUN);
    check("load_coeff_valid", 32'(flags_o.coeff_valid), 1);
    ylog.delete();
    for (int i = 0; i < 5; i++) begin
      send_x((i == 0) ? 16'd1 : 16'd0);
      send_x(16'd0);
    end
    wait_drain();
    check("imp_count", 32'(ylog.size()), 10);
    for (int i = 0; i < 5; i++) begin
      check("imp_ch0", ylog[2*i].data, w(imp[i]));
      check("imp_ch1", ylog[2*i+1].data, 0);
      check("imp_chan0", ylog[2*i].chan, 0);
      check("imp_chan1", ylog[2*i+1].chan, 1);
    end

    // Channel isolation
    reload({16'd1, 16'd1, 16'd1, 16'd1});
    pulse_clear();
    ylog.delete();
    for (int i = 0; i < 5; i++) begin
      send_x(w(100));
      send_x(w(-100));
    end
    wait_drain();
    for (int i = 0; i < 5; i++) begin
      check("iso_ch0", ylog[2*i].data, w(iso[i]));
      check("iso_ch1", ylog[2*i+1].data, w(-iso[i]));
    end

    // Clear mid-stream, with x offered during the clear cycle
    send_x(w(100));
    x_valid_i = 1'b1;
    x_data_i  = w(100);
    clear_i   = 1'b1;
    #1 check("clear_x_ready", 32'(x_ready_o), 0);
    tick();
    clear_i = 1'b0;
    check("clear_y_valid", 32'(y_valid_o), 0);
    check("clear_chan_ptr", flags_o.chan, 0);
    ylog.delete();
    send_x(w(100));
    send_x(w(-100));
    wait_drain();
    check("clear_first_ch0", ylog[0].data, w(100));
    check("clear_first_chan", ylog[0].chan, 0);
    check("clear_first_ch1", ylog[1].data, w(-100));

    // Saturation
    reload({16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF});
    pulse_clear();
    ylog.delete();
    send_x(16'h7FFF);
    send_x(16'h8000);
    wait_drain();
    check("sat_pos", ylog[0].data, 16'h7FFF);
    check("sat_neg", ylog[1].data, 16'h8000);

    // Shift and rounding
    reload({16'd0, 16'd0, 16'd0, 16'd3});
    pulse_clear();
    ctrl_i.right_shift = 6'd1;
    ylog.delete();
    send_x(16'd1);
    send_x(16'd1);
    wait_drain();
`ifdef FIR_MC_ROUND_EN
    check("shift_round", ylog[0].data, 2);
`else
    check("shift_trunc", ylog[0].data, 1);
`endif
    ctrl_i.right_shift = 6'd0;

    // Backpressure: hold y_ready low for 5 cycles with x offered
    reload({16'd4, 16'd3, 16'd2, 16'd1});
    pulse_clear();
    for (int i = 0; i < 3; i++) send_x(w($urandom_range(0, 2000) - 1000));
    y_ready_i = 1'b0;
    x_valid_i = 1'b1;
    x_data_i  = w(777);
    check("stall_pending", 32'(exp_q.size()), 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_y_valid", 32'(y_valid_o), 1);
      check("stall_y_data", y_data_o, exp_q[0].data);
      check("stall_y_chan", y_chan_o, exp_q[0].chan);
      check("stall_x_ready", 32'(x_ready_o), 0);
      tick();
    end
    y_ready_i = 1'b1;
    send_x(w(777));
    for (int i = 0; i < 4; i++) send_x(w($urandom_range(0, 2000) - 1000));
    wait_drain();

    // Reload while a result is stalled: h.ready only after y drains
    send_x(w(5));
    y_ready_i = 1'b0;
    ctrl_i.reload_h = 1'b1;
    tick();
    ctrl_i.reload_h = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_h_ready", 32'(h_ready_o), 0);
      check("drain_state", flags_o.state, DRAIN);
      tick();
    end
    y_ready_i = 1'b1;
    tick();
    check("drain_done_h_ready", 32'(h_ready_o), 1);
    check("drain_done_coeff_valid", 32'(flags_o.coeff_valid), 0);
    load_h({16'd0, 16'd0, 16'd0, 16'd2});
    ylog.delete();
    for (int i = 0; i < 6; i++) begin
      xs[i] = $urandom_range(0, 2000) - 1000;
      send_x(w(xs[i]));
    end
    wait_drain();
    for (int i = 0; i < 6; i++) check("reload_2x", ylog[i].data, w(2 * xs[i]));

    // Randomized traffic with random coefficients, shifts, stalls and clears
    reload({DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)});
    for (int i = 0; i < 600; i++) begin
      x_valid_i = ($urandom_range(0, 3) != 0);
      x_data_i  = DW'($urandom);
      y_ready_i = ($urandom_range(0, 9) < 7);
      clear_i   = ($urandom_range(0, 63) == 0);
      ctrl_i.right_shift = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                       : 6'($urandom_range(12, 18));
      tick();
    end
    x_valid_i = 1'b0;
    clear_i   = 1'b0;
    y_ready_i = 1'b1;
    wait_drain();
    ctrl_i.right_shift = 6'd0;

    // Asynchronous reset in the middle of RUN
    x_valid_i = 1'b1;
    x_data_i  = w(1234);
    for (int i = 0; i < 3; i++) begin
      #1 check("thru_x_ready", 32'(x_ready_o), 1);
      tick();
      check("thru_y_valid", 32'(y_valid_o), 1);
    end
    #2 rst_ni = 1'b0;
    #1 check_reset_values("async_rst");
    x_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    // After reset the coefficients are zero and must be reloaded
    load_h({16'd4, 16'd3, 16'd2, 16'd1});
    ylog.delete();
    send_x(w(5));
    send_x(w(7));
    wait_drain();
    base = 0;
    check("post_rst_ch0", ylog[base].data, 5);
    check("post_rst_ch1", ylog[base+1].data, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
